weight_load_ctrl: RTL and testbench

Sequencer that drives the skewed per-column weight buffer feeding the systolic array. On a start command it streams `num_tiles` weight tiles, each `SYS_ROWS` rows deep. For each tile it issues the column-0 `read` strobe, waits for the skew chain to drain across all `SYS_COLS` columns, and then hands the tile to the array with a `swap` pulse, but only when the array reports it is free. It sits between the top-level layer controller and `weight_buffer`.

---
 rtl/weight_load_ctrl_if.sv | 30 +++
 rtl/weight_load_ctrl.sv | 117 +++++++++++
 tb/tb_weight_load_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/weight_load_ctrl_if.sv
// Handshake and status bundle between the layer controller and the
// weight-load sequencer. The sequencer takes the slave side; the layer
// controller (or a testbench) takes the master side.
interface weight_load_ctrl_if #(
    parameter int SYS_ROWS = 4,
    parameter int TILE_W   = 8
);
    localparam int ROW_W = $clog2(SYS_ROWS + 1);

    logic              start;
    logic [TILE_W-1:0] num_tiles;
    logic              stall;
    logic              compute_free;
    logic              read;
    logic              swap;
    logic              busy;
    logic              done;
    logic [TILE_W-1:0] tile_idx;
    logic [ROW_W-1:0]  row_cnt;

    modport master (
        output start, num_tiles, stall, compute_free,
        input  read, swap, busy, done, tile_idx, row_cnt
    );

    modport slave (
        input  start, num_tiles, stall, compute_free,
        output read, swap, busy, done, tile_idx, row_cnt
    );
endinterface

// File: rtl/weight_load_ctrl.sv
// Weight-load sequencer: streams num_tiles tiles of SYS_ROWS rows into the
// skewed weight buffer, waits for the skew to drain across SYS_COLS columns,
// then swaps each tile into the array once the array reports it is free.
module weight_load_ctrl #(
    parameter int SYS_ROWS = 4,
    parameter int SYS_COLS = 4,
    parameter int TILE_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    weight_load_ctrl_if.slave   bus
);
    localparam int ROW_W   = $clog2(SYS_ROWS + 1);
    localparam int DRAIN_W = $clog2(SYS_COLS + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        SWAP
    } state_t;

    state_t            state_q;
    state_t            state_n;
    logic [ROW_W-1:0]  row_q;
    logic [ROW_W-1:0]  row_n;
    logic [TILE_W-1:0] tile_q;
    logic [TILE_W-1:0] tile_n;
    logic [TILE_W-1:0] count_q;
    logic [TILE_W-1:0] count_n;
    logic [DRAIN_W-1:0] drain_q;
    logic [DRAIN_W-1:0] drain_n;
    logic              read_c;
    logic              swap_c;
    logic              done_c;

    // State and counter registers; synchronous reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            tile_q  <= '0;
            count_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_n;
            row_q   <= row_n;
            tile_q  <= tile_n;
            count_q <= count_n;
            drain_q <= drain_n;
        end
    end

    // Next-state, counter updates and strobes; the last tile is detected
    // against the captured count minus one so a full-scale count never wraps.
    always_comb begin
        state_n = state_q;
        row_n   = row_q;
        tile_n  = tile_q;
        count_n = count_q;
        drain_n = drain_q;
        read_c  = 1'b0;
        swap_c  = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && (bus.num_tiles != '0)) begin
                    state_n = LOAD;
                    count_n = bus.num_tiles;
                    tile_n  = '0;
                    row_n   = '0;
                    drain_n = '0;
                end
            end
            LOAD: begin
                read_c = !bus.stall;
                if (read_c) begin
                    row_n = row_q + ROW_W'(1);
                    if (row_q == ROW_W'(SYS_ROWS - 1)) begin
                        state_n = DRAIN;
                        drain_n = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(SYS_COLS - 1)) begin
                    state_n = SWAP;
                end else begin
                    drain_n = drain_q + DRAIN_W'(1);
                end
            end
            SWAP: begin
                if (bus.compute_free) begin
                    swap_c = 1'b1;
                    if (tile_q == (count_q - TILE_W'(1))) begin
                        done_c  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        tile_n  = tile_q + TILE_W'(1);
                        row_n   = '0;
                        state_n = LOAD;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.read     = read_c;
    assign bus.swap     = swap_c;
    assign bus.done     = done_c;
    assign bus.busy     = (state_q != IDLE);
    assign bus.tile_idx = tile_q;
    assign bus.row_cnt  = row_q;
endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl: a timing model predicts every swap
// and the read pattern when a start is driven; the per-cycle monitor pops and
// compares predictions as the DUT produces swaps and reads.
module tb_weight_load_ctrl;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int TW = 8;

    typedef struct {
        int cyc;
        int tile;
        bit done;
    } exp_t;

    logic clk;
    logic rst;

    weight_load_ctrl_if #(.SYS_ROWS(R), .TILE_W(TW)) bus ();

    weight_load_ctrl #(.SYS_ROWS(R), .SYS_COLS(C), .TILE_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total_checks;
    int          bad_checks;
    exp_t        sb[$];
    logic [31:0] exp_mask;
    logic [31:0] rd_mask;
    int          exp_reads;
    int          rd_cnt;
    int          end_cyc;
    bit          busy_seen;

    int s_ntiles;
    int s_stall_lo;
    int s_stall_hi;
    int s_cf_from;
    int s_rst_cyc;
    int s_pulse_cyc;
    bit s_pulse_accept;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Timing model of one sequence started by a start sampled at the end of
    // cycle s: reads fill the non-stalled cycles, drain takes C cycles, and
    // the swap waits for compute_free.
    task automatic modelSeq(input int s, input int n);
        int c;
        int r;
        int sw;
        exp_t e;
        c = s + 1;
        for (int t = 0; t < n; t++) begin
            r = 0;
            while (r < R) begin
                if (!(c >= s_stall_lo && c <= s_stall_hi)) begin
                    if (c < 32) exp_mask[c] = 1'b1;
                    r++;
                end
                c++;
            end
            sw = c + C;
            if (sw < s_cf_from) sw = s_cf_from;
            e.cyc  = sw;
            e.tile = t;
            e.done = (t == n - 1);
            sb.push_back(e);
            c = sw + 1;
        end
        exp_reads += n * R;
        if (c + 2 > end_cyc) end_cyc = c + 2;
    endtask

    // Drive inputs for cycle k and push predictions for every start driven.
    task automatic applyStimulus(input int k);
        bus.start        = 1'b0;
        bus.stall        = (k >= s_stall_lo && k <= s_stall_hi);
        bus.compute_free = (k >= s_cf_from);
        rst              = (k == s_rst_cyc);
        if (k == s_rst_cyc) sb.delete();
        if (k == 0) begin
            bus.start     = 1'b1;
            bus.num_tiles = TW'(s_ntiles);
            if (s_ntiles != 0) modelSeq(0, s_ntiles);
        end else if (k == s_pulse_cyc) begin
            bus.start     = 1'b1;
            bus.num_tiles = s_pulse_accept ? TW'(1) : TW'(5);
            if (s_pulse_accept) modelSeq(k, 1);
        end
    endtask

    // One scenario: drive each cycle just after the edge, sample at negedge.
    task automatic runSeq(input int ntiles, input int stall_lo, input int stall_hi,
                          input int cf_from, input int rst_cyc, input int pulse_cyc,
                          input bit pulse_accept);
        exp_t e;
        s_ntiles       = ntiles;
        s_stall_lo     = stall_lo;
        s_stall_hi     = stall_hi;
        s_cf_from      = cf_from;
        s_rst_cyc      = rst_cyc;
        s_pulse_cyc    = pulse_cyc;
        s_pulse_accept = pulse_accept;
        sb.delete();
        exp_mask  = '0;
        rd_mask   = '0;
        exp_reads = 0;
        rd_cnt    = 0;
        end_cyc   = 14;
        busy_seen = 1'b0;
        for (int k = 0; k <= end_cyc && k < 5000; k++) begin
            @(posedge clk);
            #1;
            applyStimulus(k);
            @(negedge clk);
            if (k == 0) checkOutput("idle_busy_c0", bus.busy, 0);
            if (k == 3 && ntiles != 0) checkOutput("row_cnt_c3", bus.row_cnt, $countones(exp_mask[2:0]));
            if (k == rst_cyc + 1 && rst_cyc >= 0)
                checkOutput("rst_outputs",
                            {bus.busy, bus.read, bus.swap, bus.done, bus.tile_idx, bus.row_cnt}, 0);
            if (bus.busy) busy_seen = 1'b1;
            if (bus.read) begin
                rd_cnt++;
                if (k < 32) rd_mask[k] = 1'b1;
                if (sb.size() > 0) checkOutput("load_tile", bus.tile_idx, sb[0].tile);
            end
            if (bus.swap) begin
                if (sb.size() == 0) begin
                    checkOutput("swap_unexpected", k, -1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("swap_cycle", k, e.cyc);
                    checkOutput("swap_done", bus.done, e.done);
                    checkOutput("swap_tile", bus.tile_idx, e.tile);
                end
            end else if (bus.done) begin
                checkOutput("done_without_swap", 1, 0);
            end
        end
        checkOutput("read_count", rd_cnt, exp_reads);
        checkOutput("read_mask", rd_mask, exp_mask);
        checkOutput("swaps_missing", sb.size(), 0);
        checkOutput("busy_end", bus.busy, 0);
        checkOutput("busy_seen", busy_seen, (ntiles != 0) || pulse_accept);
    endtask

    initial begin
        total_checks     = 0;
        bad_checks       = 0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.num_tiles    = '0;
        bus.stall        = 1'b0;
        bus.compute_free = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs",
                    {bus.busy, bus.read, bus.swap, bus.done, bus.tile_idx, bus.row_cnt}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single tile");
        runSeq(1, 1000, -1, 0, -1, -1, 1'b0);
        $display("[TB] three tiles");
        runSeq(3, 1000, -1, 0, -1, -1, 1'b0);
        $display("[TB] stall cycles 2-3");
        runSeq(1, 2, 3, 0, -1, -1, 1'b0);
        $display("[TB] compute_free late");
        runSeq(1, 1000, -1, 15, -1, -1, 1'b0);
        $display("[TB] zero tiles");
        runSeq(0, 1000, -1, 0, -1, -1, 1'b0);
        $display("[TB] start during load ignored");
        runSeq(1, 1000, -1, 0, -1, 2, 1'b0);
        $display("[TB] reset in drain then restart");
        runSeq(1, 1000, -1, 0, 6, 8, 1'b1);
        $display("[TB] restart right after done");
        runSeq(1, 1000, -1, 0, -1, 10, 1'b1);
        $display("[TB] full-scale tile count");
        runSeq(255, 1000, -1, 0, -1, -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule
